// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one UART transmitter among N byte sources.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
   parameter int N       = 4,
   parameter int TIMEOUT = 4096,
   parameter int GAPW    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_valid,
   input  logic [8*N-1:0]       req_data,
   output logic [N-1:0]         req_ready,
   input  logic [N-1:0]         cfg_par_en,
   input  logic [N-1:0]         cfg_par_typ,
   input  logic [GAPW-1:0]      gap_cycles,
   input  logic                 tx_busy,
   output logic                 tx_data_valid,
   output logic [7:0]           tx_p_data,
   output logic                 tx_par_en,
   output logic                 tx_par_typ,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 ctrl_busy,
   output logic                 timeout_err
);

   localparam int c_IDW = $clog2(N);
   localparam int c_TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_GAP       = 2'd3
   } state_t;

   state_t           r_state;
   logic [c_IDW-1:0] r_ptr;
   logic [c_TW-1:0]  r_tmo_cnt;
   logic [GAPW-1:0]  r_gap_cnt;
   logic             r_live;
   logic             r_data_valid;
   logic [7:0]       r_p_data;
   logic             r_par_en;
   logic             r_par_typ;
   logic [c_IDW-1:0] r_grant_id;
   logic             r_timeout_err;

   logic [N-1:0]     w_hi;
   logic [N-1:0]     w_pick;
   logic [c_IDW-1:0] w_sel;
   logic             w_grant;

   // Requesters above the pointer win first; otherwise wrap to the lowest index.
   always_comb begin
      w_hi = '0;
      for (int i = 0; i < N; i++) begin
         w_hi[i] = req_valid[i] && (c_IDW'(i) > r_ptr);
      end
      w_pick = (w_hi != '0) ? w_hi : req_valid;
      w_sel  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_pick[i]) begin
            w_sel = c_IDW'(i);
         end
      end
   end

   // r_live keeps req_ready quiet while reset is held.
   assign w_grant   = r_live && (r_state == S_IDLE) && (req_valid != '0);
   assign req_ready = w_grant ? (N'(1) << w_sel) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_ptr         <= c_IDW'(N - 1);
         r_tmo_cnt     <= '0;
         r_gap_cnt     <= '0;
         r_live        <= 1'b0;
         r_data_valid  <= 1'b0;
         r_p_data      <= '0;
         r_par_en      <= 1'b0;
         r_par_typ     <= 1'b0;
         r_grant_id    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_live        <= 1'b1;
         r_timeout_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_p_data     <= req_data[{w_sel, 3'b000} +: 8];
                  r_par_en     <= cfg_par_en[w_sel];
                  r_par_typ    <= cfg_par_typ[w_sel];
                  r_grant_id   <= w_sel;
                  r_ptr        <= w_sel;
                  r_tmo_cnt    <= '0;
                  r_data_valid <= 1'b1;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (tx_busy) begin
                  r_data_valid <= 1'b0;
                  r_state      <= S_WAIT_DONE;
               end else if (r_tmo_cnt == c_TW'(TIMEOUT - 1)) begin
                  // Pointer is left on the failed requester so the next grant moves on.
                  r_timeout_err <= 1'b1;
                  r_data_valid  <= 1'b0;
                  r_state       <= S_IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (!tx_busy) begin
                  r_gap_cnt <= gap_cycles;
                  r_state   <= (gap_cycles != '0) ? S_GAP : S_IDLE;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == GAPW'(1)) begin
                  r_state <= S_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign tx_data_valid = r_data_valid;
   assign tx_p_data     = r_p_data;
   assign tx_par_en     = r_par_en;
   assign tx_par_typ    = r_par_typ;
   assign grant_id      = r_grant_id;
   assign timeout_err   = r_timeout_err;
   assign ctrl_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter with a simple busy model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int N       = 4;
   localparam int TIMEOUT = 16;
   localparam int GAPW    = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [8*N-1:0]  req_data;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    cfg_par_en;
   logic [N-1:0]    cfg_par_typ;
   logic [GAPW-1:0] gap_cycles;
   logic            tx_busy;
   logic            tx_data_valid;
   logic [7:0]      tx_p_data;
   logic            tx_par_en;
   logic            tx_par_typ;
   logic [1:0]      grant_id;
   logic            ctrl_busy;
   logic            timeout_err;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .GAPW(GAPW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .cfg_par_en   (cfg_par_en),
      .cfg_par_typ  (cfg_par_typ),
      .gap_cycles   (gap_cycles),
      .tx_busy      (tx_busy),
      .tx_data_valid(tx_data_valid),
      .tx_p_data    (tx_p_data),
      .tx_par_en    (tx_par_en),
      .tx_par_typ   (tx_par_typ),
      .grant_id     (grant_id),
      .ctrl_busy    (ctrl_busy),
      .timeout_err  (timeout_err)
   );

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
      logic       pe;
      logic       pt;
      logic       to;
   } frame_t;

   frame_t     exp_q[$];
   logic [7:0] src_mem [N][16];
   int         src_len [N];
   int         src_pos [N];
   int         busy_len;
   int         n_chk = 0;
   int         n_err = 0;
   int         n_to  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic drive_reqs();
      for (int k = 0; k < N; k++) begin
         req_valid[k]       = (src_pos[k] < src_len[k]);
         req_data[8*k +: 8] = (src_pos[k] < src_len[k]) ? src_mem[k][src_pos[k][3:0]] : 8'h00;
      end
   endtask

   task automatic push_req(input int k, input logic [7:0] b);
      src_mem[k][src_len[k][3:0]] = b;
      src_len[k]++;
      drive_reqs();
   endtask

   task automatic push_exp(input logic [1:0] id, input logic [7:0] d,
                           input logic pe, input logic pt, input logic to);
      frame_t f;
      f.id = id; f.data = d; f.pe = pe; f.pt = pt; f.to = to;
      exp_q.push_back(f);
   endtask

   task automatic wait_idle(input string nm);
      int g = 0;
      while ((exp_q.size() != 0 || ctrl_busy || tx_busy || req_valid != '0) && g < 2000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 2000) begin
         n_chk++; n_err++;
         $display("FAIL %s idle wait expired, pending=%0d required=0", nm, exp_q.size());
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_valid(input string nm);
      int g = 0;
      while (!tx_data_valid && g < 200) begin
         @(negedge clk); #1;
         g++;
      end
      if (g >= 200) begin
         n_chk++; n_err++;
         $display("FAIL %s valid wait expired, actual=0 required=1", nm);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
   endtask

   // Requester side: a byte is consumed on the edge where valid & ready held.
   initial begin : drv
      logic [N-1:0] acc;
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         if (acc != '0) begin
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
               if (acc[k]) src_pos[k]++;
            end
            drive_reqs();
         end
      end
   end

   // Transmitter model: goes busy for busy_len cycles after seeing data_valid.
   initial begin : txm
      int cnt;
      cnt = 0;
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            tx_busy = 1'b0;
            cnt = 0;
         end else if (tx_busy) begin
            cnt--;
            if (cnt == 0) tx_busy = 1'b0;
         end else if (tx_data_valid && busy_len > 0) begin
            tx_busy = 1'b1;
            cnt = busy_len;
         end
      end
   end

   // Monitor: pops one expected frame per tx_data_valid rise.
   initial begin : mon
      frame_t cur;
      logic   prev_v, prev_b, prev_rdy, sbad;
      int     vcnt;
      cur = '0; prev_v = 0; prev_b = 0; prev_rdy = 0; sbad = 0; vcnt = 0;
      forever begin
         @(negedge clk);
         if (req_ready != '0) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL ready_unexpected actual=%0h required=0", req_ready);
            end else begin
               chk("req_ready_onehot", {28'd0, req_ready}, 32'd1 << exp_q[0].id);
            end
         end
         if (tx_data_valid && !prev_v) begin
            chk("ready_to_valid_latency", {31'd0, prev_rdy}, 32'd1);
            if (exp_q.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL frame_unexpected actual=%0h required=none", tx_p_data);
            end else begin
               cur = exp_q.pop_front();
               chk("grant_id", {30'd0, grant_id}, {30'd0, cur.id});
               chk("p_data", {24'd0, tx_p_data}, {24'd0, cur.data});
               chk("par_cfg", {30'd0, tx_par_en, tx_par_typ}, {30'd0, cur.pe, cur.pt});
            end
            vcnt = 0;
            sbad = 0;
         end
         if (tx_data_valid) vcnt++;
         if (!tx_data_valid && prev_v) begin
            chk("valid_length", vcnt, cur.to ? TIMEOUT : 1);
            chk("timeout_err", {31'd0, timeout_err}, {31'd0, cur.to});
         end
         if (ctrl_busy && ({grant_id, tx_p_data, tx_par_en, tx_par_typ} !=
                           {cur.id, cur.data, cur.pe, cur.pt})) sbad = 1;
         if (!ctrl_busy && prev_b) chk("frame_stable", {31'd0, sbad}, 32'd0);
         if (timeout_err) n_to++;
         prev_v   = tx_data_valid;
         prev_b   = ctrl_busy;
         prev_rdy = (req_ready != '0);
      end
   end

   initial begin : watchdog
      #200us;
      $display("FAIL watchdog expired, checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n, ngap, g;
      rst = 1'b0;
      req_valid = '0; req_data = '0; cfg_par_en = '0; cfg_par_typ = '0;
      gap_cycles = '0; busy_len = 20;
      for (int k = 0; k < N; k++) begin
         src_len[k] = 0;
         src_pos[k] = 0;
      end
      repeat (3) @(negedge clk);
      chk("reset_state", {13'd0, tx_data_valid, tx_par_en, tx_par_typ, ctrl_busy,
                          timeout_err, grant_id, tx_p_data, req_ready}, 32'd0);
      @(posedge clk); #2 rst = 1'b1;

      // single frame from requester 0
      cfg_par_en[0] = 1'b1; cfg_par_typ[0] = 1'b0;
      push_exp(2'd0, 8'hA5, 1, 0, 0);
      push_req(0, 8'hA5);
      wait_idle("single");

      // rotation with all four valid
      do_reset();
      cfg_par_en = 4'b1111; cfg_par_typ = 4'b1010; gap_cycles = 8'd0;
      push_exp(2'd0, 8'h10, 1, 0, 0); push_exp(2'd1, 8'h11, 1, 1, 0);
      push_exp(2'd2, 8'h12, 1, 0, 0); push_exp(2'd3, 8'h13, 1, 1, 0);
      push_exp(2'd0, 8'h14, 1, 0, 0); push_exp(2'd1, 8'h15, 1, 1, 0);
      @(posedge clk); #2;
      push_req(0, 8'h10); push_req(1, 8'h11); push_req(2, 8'h12);
      push_req(3, 8'h13); push_req(0, 8'h14); push_req(1, 8'h15);
      wait_idle("rotation");

      // idle gap of 5 cycles between frames
      gap_cycles = 8'd5;
      push_exp(2'd2, 8'h5A, 1, 0, 0); push_exp(2'd3, 8'hC3, 1, 1, 0);
      @(posedge clk); #2;
      push_req(2, 8'h5A); push_req(3, 8'hC3);
      g = 0;
      while (!tx_busy && g < 100) begin @(negedge clk); #1; g++; end
      g = 0;
      while (tx_busy && g < 100) begin @(negedge clk); #1; g++; end
      n = 0; ngap = 0;
      while (req_ready == '0 && n < 100) begin
         @(negedge clk); #1;
         n++;
         if (ctrl_busy) ngap++;
      end
      chk("busy_fall_to_ready", n, 6);
      chk("gap_cycles_seen", ngap, 5);
      wait_idle("gap");
      gap_cycles = 8'd0;

      // timeout, then the next valid requester is granted
      busy_len = 0;
      push_exp(2'd0, 8'h77, 1, 0, 1); push_exp(2'd1, 8'h88, 1, 1, 0);
      @(posedge clk); #2;
      push_req(0, 8'h77); push_req(1, 8'h88);
      g = 0;
      while (!timeout_err && g < 100) begin @(negedge clk); #1; g++; end
      chk("timeout_seen", {31'd0, timeout_err}, 32'd1);
      @(posedge clk); #2 busy_len = 20;
      wait_idle("timeout");

      // per-requester parity config, changed mid-frame without effect
      cfg_par_en[1] = 1'b0; cfg_par_typ[1] = 1'b1; cfg_par_typ[2] = 1'b1;
      push_exp(2'd2, 8'h96, 1, 1, 0); push_exp(2'd1, 8'h69, 0, 1, 0);
      @(posedge clk); #2;
      push_req(2, 8'h96); push_req(1, 8'h69);
      wait_valid("cfg");
      @(posedge clk); #2 cfg_par_typ[2] = 1'b0;
      wait_idle("cfg");

      // reset during WAIT_DONE; pointer returns to N-1
      push_exp(2'd2, 8'h3C, 1, 0, 0);
      @(posedge clk); #2;
      push_req(2, 8'h3C);
      wait_valid("rst_mid");
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1 chk("async_reset_outputs", {14'd0, tx_data_valid, tx_par_en, tx_par_typ, ctrl_busy,
                                     grant_id, tx_p_data, req_ready}, 32'd0);
      push_exp(2'd0, 8'h01, 1, 0, 0); push_exp(2'd3, 8'h03, 1, 1, 0);
      push_req(0, 8'h01); push_req(3, 8'h03);
      #1 chk("ready_in_reset", {28'd0, req_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      wait_idle("after_reset");

      chk("scoreboard_empty", exp_q.size(), 0);
      chk("timeout_pulses", n_to, 1);
      for (int k = 0; k < N; k++) chk("bytes_consumed", src_pos[k], src_len[k]);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
